// File: rtl/ar_pkg.sv
// ar_pkg: shared types and widths for the ARINC transmit scheduler
package ar_pkg;
  localparam int NSLOT = 4;
  localparam int AW = 8;
  localparam int DW = 23;
  localparam int VW = 2;
  localparam int PW = 8;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  typedef struct packed {
    logic          en;
    logic [PW-1:0] per;
    logic [VW-1:0] vel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } slot_t;
endpackage

// File: rtl/ar_tx_sched_if.sv
// ar_tx_sched_if: configuration, tick and transmitter handshake bundle
interface ar_tx_sched_if;
  import ar_pkg::*;
  logic             ce1ms;
  logic             cfg_we;
  logic [1:0]       cfg_slot;
  logic             cfg_en;
  logic [PW-1:0]    cfg_per;
  logic [VW-1:0]    cfg_vel;
  logic [AW-1:0]    cfg_adr;
  logic [DW-1:0]    cfg_dat;
  logic             en_tx;
  logic             st;
  logic [AW-1:0]    ADR;
  logic [DW-1:0]    DAT;
  logic [VW-1:0]    Nvel;
  logic [1:0]       slot_act;
  logic             busy;
  logic [NSLOT-1:0] ovr;
  logic             err_to;
  modport master (
    output ce1ms, cfg_we, cfg_slot, cfg_en, cfg_per, cfg_vel, cfg_adr, cfg_dat, en_tx,
    input  st, ADR, DAT, Nvel, slot_act, busy, ovr, err_to
  );
  modport slave (
    input  ce1ms, cfg_we, cfg_slot, cfg_en, cfg_per, cfg_vel, cfg_adr, cfg_dat, en_tx,
    output st, ADR, DAT, Nvel, slot_act, busy, ovr, err_to
  );
endinterface

// File: rtl/ar_rr_arb.sv
// ar_rr_arb: round-robin pick of the first pending slot after the last grant
module ar_rr_arb (
  input  logic [3:0] pending,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);
  // scan from farthest to nearest so the slot right after last wins
  always_comb begin
    grant = last;
    for (int i = 4; i >= 1; i--) grant = pending[last + 2'(i)] ? last + 2'(i) : grant;
  end
  assign valid = |pending;
endmodule

// File: rtl/ar_tx_sched.sv
// ar_tx_sched: periodic per-slot ARINC word scheduler feeding one transmitter
module ar_tx_sched import ar_pkg::*; #(
  parameter int NSLOT  = 4,
  parameter int TO_CYC = 16
) (
  input logic           clk,
  input logic           R,
  ar_tx_sched_if.slave  bus
);
  localparam int TW = $clog2(TO_CYC + 1);
  state_t           state, nxt;
  slot_t            slot [NSLOT];
  logic [PW-1:0]    cnt [NSLOT];
  logic [NSLOT-1:0] pend, tick, expire, take, ovr;
  logic [1:0]       grant, act;
  logic             valid, err, to;
  logic [TW-1:0]    tcnt;
  logic [AW-1:0]    adr;
  logic [DW-1:0]    dat;
  logic [VW-1:0]    vel;
  ar_rr_arb u_arb (.pending(pend), .last(act), .grant(grant), .valid(valid));
  assign to = tcnt == TW'(TO_CYC - 1);
  // per-slot ms tick, period expiry and grant decode
  always_comb begin
    tick = '0;
    expire = '0;
    take = '0;
    for (int i = 0; i < NSLOT; i++) begin
      tick[i] = bus.ce1ms & slot[i].en & (slot[i].per != '0);
      expire[i] = tick[i] & (cnt[i] == PW'(1));
      take[i] = (state == IDLE) & valid & (grant == 2'(i));
    end
  end
  // slot config, down-counters, pending and sticky overrun; an expiry on the granted slot re-arms pending
  always_ff @(posedge clk)
    if (R) begin
      pend <= '0;
      ovr <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot[i] <= '0;
        cnt[i] <= '0;
      end
    end else
      for (int i = 0; i < NSLOT; i++)
        if (bus.cfg_we && bus.cfg_slot == 2'(i)) begin
          slot[i] <= '{en: bus.cfg_en, per: bus.cfg_per, vel: bus.cfg_vel, adr: bus.cfg_adr, dat: bus.cfg_dat};
          cnt[i] <= bus.cfg_per;
          pend[i] <= 1'b0;
          ovr[i] <= 1'b0;
        end else begin
          cnt[i] <= expire[i] ? slot[i].per : tick[i] ? cnt[i] - PW'(1) : cnt[i];
          pend[i] <= expire[i] | (pend[i] & ~take[i]);
          ovr[i] <= ovr[i] | (expire[i] & pend[i] & ~take[i]);
        end
  // state register
  always_ff @(posedge clk)
    state <= R ? IDLE : nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = valid ? START : IDLE;
      START:     nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = bus.en_tx ? WAIT_DONE : to ? IDLE : WAIT_BUSY;
      WAIT_DONE: nxt = bus.en_tx ? WAIT_DONE : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    bus.st = state == START;
    bus.busy = state != IDLE;
  end
  // word capture at grant, busy-wait timer and sticky timeout
  always_ff @(posedge clk)
    if (R) begin
      adr <= '0;
      dat <= '0;
      vel <= '0;
      act <= 2'd3;
      err <= 1'b0;
      tcnt <= '0;
    end else begin
      if (state == IDLE && valid) begin
        adr <= slot[grant].adr;
        dat <= slot[grant].dat;
        vel <= slot[grant].vel;
        act <= grant;
      end
      tcnt <= state == WAIT_BUSY ? tcnt + TW'(1) : '0;
      err <= err | (state == WAIT_BUSY & ~bus.en_tx & to);
    end
  assign bus.ADR = adr;
  assign bus.DAT = dat;
  assign bus.Nvel = vel;
  assign bus.slot_act = act;
  assign bus.ovr = ovr;
  assign bus.err_to = err;
endmodule

// File: doc/ar_tx_sched.md
AR_TX_SCHED -- requirements
Module: ar_tx_sched

Interface
REQ-001 Parameter NSLOT, default 4: number of schedule slots; fixed at 4 for this release.
REQ-002 Parameter TO_CYC, default 16: clk cycles allowed between st and en_tx rising.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 R  in  1  reset, synchronous, active-high.
REQ-005 ce1ms  in  1  one-cycle 1 ms tick.
REQ-006 cfg_we  in  1  config write strobe, one cycle.
REQ-007 cfg_slot  in  2  slot index to write.
REQ-008 cfg_en, cfg_per, cfg_vel  in  1/8/2  slot enable, period in ms, baud select.
REQ-009 cfg_adr, cfg_dat  in  8/23  ARINC label and data for the slot.
REQ-010 en_tx  in  1  transmitter busy, high while a word is on the line.
REQ-011 st  out  1  one-cycle start pulse to the transmitter.
REQ-012 ADR, DAT, Nvel  out  8/23/2  word presented to the transmitter, registered.
REQ-013 slot_act  out  2  index of the slot last granted.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 ovr  out  4  sticky per-slot overrun flags.
REQ-016 err_to  out  1  sticky transmitter-timeout flag.

Function
REQ-017 Each slot SHALL hold en, per, vel, adr, dat registers, an 8-bit ms down-counter and a pending bit.
REQ-018 A cfg_we SHALL load all fields of cfg_slot, reload its counter with cfg_per, clear its pending bit and clear its ovr bit.
REQ-019 On ce1ms, each enabled slot with per!=0 SHALL decrement its counter; when the counter is 1, it SHALL reload per and set pending instead.
REQ-020 A slot with en=0 or per=0 SHALL never set pending.
REQ-021 If expiry occurs while pending=1 and the slot is not granted that cycle, ovr[slot] SHALL set; the pending bit stays at 1.
REQ-022 If expiry and grant of the same slot coincide, pending SHALL remain 1 and ovr SHALL NOT set.
REQ-023 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE: if any pending bit is set, the FSM SHALL grant round-robin starting at slot_act+1, clear that pending bit, and register adr/dat/vel into ADR/DAT/Nvel and the index into slot_act; next state START.
REQ-025 START: st=1 for exactly this cycle; next state WAIT_BUSY.
REQ-026 WAIT_BUSY: on en_tx=1 go to WAIT_DONE; after TO_CYC cycles without it, set err_to and go to IDLE.
REQ-027 WAIT_DONE: on en_tx=0 go to IDLE.
REQ-028 Latency: st SHALL assert exactly 1 cycle after the IDLE grant cycle, and exactly 2 cycles after the ce1ms that set pending.
REQ-029 A cfg_we to the slot in flight SHALL NOT alter ADR/DAT/Nvel until the next grant.
REQ-030 ADR/DAT/Nvel SHALL be stable from grant until the return to IDLE.

Reset
REQ-031 R SHALL force IDLE, st=0, busy=0, ADR=0, DAT=0, Nvel=0, slot_act=3 (first grant favours slot 0), ovr=0, err_to=0, all pending=0, all en=0, per=0, counters=0.
REQ-032 R asserted mid-transfer SHALL abort to IDLE next cycle; en_tx is ignored until a new grant.

Structure
REQ-033 Package ar_pkg SHALL hold the FSM state enum, NSLOT, and the widths 8/23/2.
REQ-034 The round-robin selector SHALL be one sub-module ar_rr_arb (inputs: pending[3:0], last[1:0]; outputs: grant index, valid).

Verification
REQ-035 Slot0 per=3, en=1, en_tx pulses high 5 cycles after st -> st once every 3 ce1ms, ADR=slot0 label, busy spans the transfer.
REQ-036 Slots 0-3 pending simultaneously, slot_act=1 -> grant order 2,3,0,1.
REQ-037 Slot1 per=1, en_tx held high 3 ms -> ovr[1]=1, one st per transfer, a cfg_we to slot 1 clears ovr[1].
REQ-038 en_tx stuck at 0 after st -> err_to=1 after 16 cycles, FSM in IDLE.
REQ-039 cfg_we to slot 0 with dat=23'h12345 during WAIT_DONE -> DAT unchanged until the next grant, which then outputs 23'h12345.
REQ-040 R asserted in WAIT_BUSY -> next cycle all outputs are at their reset values and no st occurs until reconfigured.
